// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and scan FSM encoding
//
// Purpose : constants used by the display scanners. Segment byte layout is
//           bit7..bit0 = a,b,c,d,e,f,g,dp, active-high.
// Ports   : none (package).
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Digit "0": segments a-f lit, g and dp dark.
    localparam logic [7:0] SEG_ZERO  = 8'b1111_1100;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // True when the pattern shows a zero, regardless of the decimal point.
    function automatic logic is_zero_pattern(input logic [7:0] pat);
        logic [7:0] mask;
        mask         = 8'hFF;
        mask[SEG_DP] = 1'b0;
        return (pat & mask) == (SEG_ZERO & mask);
    endfunction

endpackage

// File: rtl/scan_tick.sv
// rtl/scan_tick.sv - slot counter with slot-end and blank-end strobes
//
// Purpose : counts 0..DIV-1 while en is high and wraps; held at 0 while en
//           is low. Strobes are combinational and qualified by en so a
//           disabled scanner never sees a slot boundary.
// Ports   : clk_in    - clock
//           rst       - synchronous, active-high reset
//           en        - count enable (low clears the count)
//           slot_cnt  - current position within the slot
//           slot_end  - high on the last cycle of the slot
//           blank_end - high on the last blanking cycle of the slot
module scan_tick #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16,
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] slot_cnt,
    output logic          slot_end,
    output logic          blank_end
);

    localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK - 1);

    if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
        $error("scan_tick: BLANK must satisfy 1 <= BLANK < DIV");
    end

    always_ff @(posedge clk_in) begin
        if (rst || !en) begin
            slot_cnt <= '0;
        end else if (slot_cnt == LAST_CNT) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    assign slot_end  = en && (slot_cnt == LAST_CNT);
    assign blank_end = en && (slot_cnt == BLANK_CNT);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed 7-segment scanner with inter-digit blanking
//
// Purpose : scans N_DIG segment patterns onto one shared bus. Each slot is
//           BLANK_CYC cycles of all-commons-off followed by the drive phase.
//           The digit pattern is captured at the end of blanking so bus
//           changes mid-slot never tear the displayed digit.
//           Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking).
// Ports   : clk_in     - clock
//           rst        - synchronous, active-high reset
//           seg_bus    - digit k pattern at [8k+7:8k], digit 0 rightmost
//           scan_en    - 1 runs the scan, 0 holds everything blank at digit 0
//           seg_out    - shared segment bus, active-high
//           seg_com    - digit commons, active-low, at most one low
//           frame_done - one-cycle pulse after the last digit slot ends
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIG     = 6,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [8*N_DIG-1:0] seg_bus,
    input  logic               scan_en,
    output logic [7:0]         seg_out,
    output logic [N_DIG-1:0]   seg_com,
    output logic               frame_done
);

    localparam int             DW       = $clog2(N_DIG);
    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  LAST_DIG = DW'(N_DIG - 1);

    if (N_DIG < 2 || N_DIG > 8) begin : g_bad_ndig
        $error("seg_scan_mux: N_DIG must be in 2..8");
    end

    logic [CW-1:0] slot_cnt_unused;
    logic          slot_end;
    logic          blank_end;

    scan_tick #(
        .DIV   (SCAN_DIV),
        .BLANK (BLANK_CYC)
    ) u_tick (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (scan_en),
        .slot_cnt  (slot_cnt_unused),
        .slot_end  (slot_end),
        .blank_end (blank_end)
    );

    logic [7:0] digit_pat [N_DIG];
    for (genvar k = 0; k < N_DIG; k++) begin : g_unpack
        assign digit_pat[k] = seg_bus[8*k +: 8];
    end

    scan_state_e        state_q, state_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic [7:0]         snap_q, snap_d;
    logic [7:0]         seg_out_d;
    logic [N_DIG-1:0]   seg_com_d;
    logic               frame_d;
    logic               suppress;

    // Capture happens on the BLANK->DRIVE edge only.
    assign snap_d = (scan_en && state_q == ST_BLANK && blank_end) ? digit_pat[dig_q] : snap_q;

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it reads zero and every digit above it
    // reads zero too; a suppressed digit is itself a zero, so the recursive
    // definition collapses to "all higher digits are zero".
    logic [N_DIG-1:1] pat_zero;
    logic [N_DIG-1:0] upper_zero;

    for (genvar k = 1; k < N_DIG; k++) begin : g_zero
        assign pat_zero[k] = is_zero_pattern(digit_pat[k]);
    end

    for (genvar k = 0; k < N_DIG; k++) begin : g_upper
        if (k == N_DIG - 1) begin : g_top
            assign upper_zero[k] = 1'b1;
        end else begin : g_rest
            assign upper_zero[k] = &pat_zero[N_DIG-1:k+1];
        end
    end

    assign suppress = (dig_q != '0) && is_zero_pattern(snap_d) && upper_zero[dig_q];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        seg_out_d = SEG_BLANK;
        seg_com_d = '1;
        frame_d   = 1'b0;

        if (scan_en) begin
            case (state_q)
                ST_BLANK: begin
                    if (blank_end) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (slot_end) begin
                        state_d = ST_BLANK;
                        frame_d = (dig_q == LAST_DIG);
                        dig_d   = (dig_q == LAST_DIG) ? '0 : dig_q + DW'(1);
                    end
                end
                default: state_d = ST_BLANK;
            endcase

            // Outputs follow the next state so commons and segments switch
            // together on the same edge.
            if (state_d == ST_DRIVE) begin
                seg_com_d[dig_q] = 1'b0;
                seg_out_d        = suppress ? SEG_BLANK : snap_d;
            end
        end else begin
            state_d = ST_BLANK;
            dig_d   = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            dig_q      <= '0;
            snap_q     <= SEG_BLANK;
            seg_out    <= SEG_BLANK;
            seg_com    <= '1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig_q      <= dig_d;
            snap_q     <= snap_d;
            seg_out    <= seg_out_d;
            seg_com    <= seg_com_d;
            frame_done <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

    localparam int N   = 6;
    localparam int DIV = 8;
    localparam int BL  = 2;

    logic             clk_in;
    logic             rst;
    logic [8*N-1:0]   seg_bus;
    logic             scan_en;
    logic [7:0]       seg_out;
    logic [N-1:0]     seg_com;
    logic             frame_done;

    seg_scan_mux #(
        .N_DIG     (N),
        .SCAN_DIV  (DIV),
        .BLANK_CYC (BL)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .seg_bus    (seg_bus),
        .scan_en    (scan_en),
        .seg_out    (seg_out),
        .seg_com    (seg_com),
        .frame_done (frame_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_bad   = 0;
    int fd_cnt  = 0;

    // Reference position: digit, slot cycle, and frame_done expected now.
    int         m_d  = 0;
    int         m_c  = 0;
    logic       m_fd = 1'b0;
    logic [7:0] snap_m [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h digit=%0d slot=%0d t=%0t",
                     tag, got, exp, m_d, m_c, $time);
        end
    endtask

    function automatic logic [7:0] bus_digit(input int d);
        return seg_bus[d*8 +: 8];
    endfunction

    function automatic bit lz_suppressed(input int d);
`ifdef SEG_SCAN_LZB_EN
        if (d == 0) return 1'b0;
        if ((snap_m[d] & 8'hFE) != 8'hFC) return 1'b0;
        for (int j = d + 1; j < N; j++) begin
            if ((bus_digit(j) & 8'hFE) != 8'hFC) return 1'b0;
        end
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    // Check the current cycle against the reference, then advance one clock.
    task automatic cyc();
        logic [7:0]   eo;
        logic [N-1:0] ec;
        logic [N-1:0] one;
        one = 1;
        if (m_c == BL - 1) snap_m[m_d] = bus_digit(m_d);
        if (m_c >= BL) begin
            ec = ~(one << m_d);
            eo = lz_suppressed(m_d) ? 8'h00 : snap_m[m_d];
        end else begin
            ec = '1;
            eo = 8'h00;
        end
        check("seg_out", seg_out, eo);
        check("seg_com", seg_com, ec);
        check("frame_done", frame_done, m_fd);
        check("com_onehot", $countones(~seg_com) <= 1, 1);
        check("blank_dark", (seg_com == '1) ? seg_out : 8'h00, 8'h00);
        if (frame_done) fd_cnt++;
        if (rst || !scan_en) begin
            m_c  = 0;
            m_d  = 0;
            m_fd = 1'b0;
        end else begin
            m_fd = (m_c == DIV - 1) && (m_d == N - 1);
            if (m_c == DIV - 1) begin
                m_c = 0;
                m_d = (m_d == N - 1) ? 0 : m_d + 1;
            end else begin
                m_c++;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic run_until(input int d, input int c);
        int n;
        n = 0;
        while (!(m_d == d && m_c == c) && n < 200) begin
            cyc();
            n++;
        end
        check("reach_slot", (m_d == d && m_c == c), 1);
    endtask

    initial begin
        int n_blank;
        rst     = 1'b1;
        scan_en = 1'b0;
        seg_bus = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < N; i++) snap_m[i] = 8'h00;

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_seg_out", seg_out, 8'h00);
        check("rst_seg_com", seg_com, 6'b111111);
        check("rst_frame_done", frame_done, 0);

        // Basic scan: two full frames, one frame_done pulse at cycle 48.
        rst     = 1'b0;
        scan_en = 1'b1;
        fd_cnt  = 0;
        repeat (2 * N * DIV) cyc();
        check("fd_count", fd_cnt, 1);

        // Snapshot holds for the current slot; new value next frame.
        run_until(2, 4);
        seg_bus[2*8 +: 8] = 8'hFF;
        cyc();
        check("snap_hold", seg_out, 8'h03);
        repeat (N * DIV - 1) cyc();
        check("snap_next", seg_out, 8'hFF);
        seg_bus[2*8 +: 8] = 8'h03;

        // Reset mid-slot.
        run_until(3, 5);
        rst = 1'b1;
        cyc();
        check("midrst_seg_out", seg_out, 8'h00);
        check("midrst_seg_com", seg_com, 6'b111111);
        check("midrst_fd", frame_done, 0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        check("post_rst_d0_com", seg_com, 6'b111110);
        check("post_rst_d0_seg", seg_out, 8'h01);

        // scan_en low for 20 cycles mid-frame.
        run_until(4, 3);
        scan_en = 1'b0;
        repeat (20) cyc();
        scan_en = 1'b1;
        n_blank = 0;
        while (seg_com == '1 && n_blank < 10) begin
            n_blank++;
            cyc();
        end
        check("reen_blank_cycles", n_blank, BL);
        check("reen_d0_com", seg_com, 6'b111110);

        // Leading-zero pattern: 5..0 = ZERO, ZERO, 0x60, ZERO, ZERO, ZERO.
        run_until(0, 0);
        seg_bus = {8'hFC, 8'hFC, 8'h60, 8'hFC, 8'hFC, 8'hFC};
        run_until(3, 4);
        check("lz_d3", seg_out, 8'h60);
        run_until(4, 4);
`ifdef SEG_SCAN_LZB_EN
        check("lz_d4", seg_out, 8'h00);
`else
        check("lz_d4", seg_out, 8'hFC);
`endif
        run_until(5, 4);
`ifdef SEG_SCAN_LZB_EN
        check("lz_d5", seg_out, 8'h00);
`else
        check("lz_d5", seg_out, 8'hFC);
`endif
        check("lz_d5_com", seg_com, 6'b011111);

        // All-zero input.
        run_until(0, 0);
        seg_bus = {N{8'hFC}};
        run_until(0, 4);
        check("allz_d0", seg_out, 8'hFC);
        run_until(1, 4);
`ifdef SEG_SCAN_LZB_EN
        check("allz_d1", seg_out, 8'h00);
`else
        check("allz_d1", seg_out, 8'hFC);
`endif
        repeat (N * DIV) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Consumes the per-digit 8-bit segment patterns produced by the digit counter/decoder blocks (seconds, minutes and hours digits).
- Time-multiplexes them onto one shared segment bus with a one-hot digit-common select, for the board's multiplexed 6-digit display.
- Inserts a blanking gap between digits to suppress ghosting.
- Emits a once-per-frame pulse.

Parameters:
- N_DIG, 6, number of digits scanned (2..8)
- SCAN_DIV, 1000, clk_in cycles per digit slot (blank + drive)
- BLANK_CYC, 16, cycles at slot start with all commons off; must satisfy 1 <= BLANK_CYC < SCAN_DIV (elaboration error otherwise)

Ports:
- clk_in  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_bus  input  8*N_DIG  digit k pattern at bits [8k+7:8k]; digit 0 is rightmost; bit7..bit0 = a,b,c,d,e,f,g,dp; active-high
- scan_en  input  1  1 = scanning runs; 0 = hold in blank
- seg_out  output  8  shared segment bus, active-high
- seg_com  output  N_DIG  digit commons, active-low, at most one bit low
- frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (rst=1 at a clk_in edge):
  - slot_cnt=0, dig_idx=0, state=BLANK.
  - seg_out=8'h00, seg_com=all ones, frame_done=0.
  - Applies mid-slot with no partial drive afterwards.
- slot_cnt counts 0..SCAN_DIV-1 and wraps. dig_idx increments when slot_cnt wraps; N_DIG-1 -> 0.
- FSM states: BLANK and DRIVE.
  - BLANK: slot_cnt in 0..BLANK_CYC-1. seg_out=0, seg_com=all ones.
  - BLANK -> DRIVE: when slot_cnt = BLANK_CYC-1. On that edge, snapshot seg_bus[dig_idx] into an internal register.
  - DRIVE: slot_cnt in BLANK_CYC..SCAN_DIV-1. seg_out=snapshot, seg_com bit dig_idx=0, others 1.
  - DRIVE -> BLANK: when slot_cnt = SCAN_DIV-1. dig_idx advances on the same edge.
- All outputs are registered. seg_com and seg_out change on the same edge, so no cycle has a new common paired with stale segment data.
- Snapshot rule: seg_bus changes during DRIVE do not affect the current slot. They appear in the digit's next slot.
- frame_done is 1 on the cycle after the edge where dig_idx wraps N_DIG-1 -> 0.
- scan_en=0:
  - Counters are held and cleared to slot_cnt=0, dig_idx=0, state=BLANK.
  - Outputs are blank; frame_done=0.
  - When scan_en returns to 1, scanning restarts at digit 0, slot start.
- Simultaneous rst and scan_en: rst wins.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During DRIVE, digit k (k >= 1) is suppressed (seg_out=0, its common still driven) if its snapshot equals SEG_ZERO and every higher digit's current seg_bus equals SEG_ZERO or is itself suppressed.
  - Digit 0 is never suppressed.
  - The comparison ignores the dp bit.
- Undefined: all digits are shown as received. The suppression logic is absent.

Decomposition:
- Package seg_pkg holds:
  - SEG_ZERO = 8'b1111_1100 (segments a-f on, g off, dp off)
  - SEG_BLANK = 8'h00
  - segment bit-position constants SEG_A..SEG_DP
  - the 2-state FSM encoding
- Sub-module scan_tick: parameterized slot counter. Outputs slot_cnt, slot_end and blank_end strobes; reused by future LED/keypad scanners.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, N_DIG=6 unless noted):
1. Reset then scan_en=1, digits patterns 0x01..0x06 -> each slot: 2 cycles seg_com=6'b111111/seg_out=0, then 6 cycles seg_com with bit k low and seg_out=k+1. frame_done pulses once every 48 cycles.
2. Change seg_bus digit 2 from 0x03 to 0xFF at slot cycle 4 of digit 2 -> seg_out stays 0x03 for that slot; 0xFF shown in the next frame's digit-2 slot.
3. Assert rst at slot cycle 5 of digit 3 -> next cycle all outputs at reset values. After release, digit 0 blank phase begins.
4. Deassert scan_en for 20 cycles mid-frame -> outputs blank, frame_done stays 0. On re-enable, digit 0 is driven after exactly 2 blank cycles.
5. Every cycle, check at most one seg_com bit is low, and seg_out=0 whenever seg_com is all ones.
6. With SEG_SCAN_LZB_EN, digits 5..0 = SEG_ZERO,SEG_ZERO,0x60,SEG_ZERO,SEG_ZERO,SEG_ZERO -> digits 5 and 4 slots drive seg_out=0. Digits 3..0 show their patterns (0x60, then SEG_ZERO x3). All-zero input shows only digit 0 as SEG_ZERO.
